led_cube_single_frame: RTL and testbench
========================================

# led_cube_single_frame

Drives one 64-byte frame onto an 8×8×8 LED cube using layer multiplexing: for each of 8 layers, it loads 8 column latches with one byte each, then enables that layer for a fixed on-time. The frame refreshes continuously until stopped. It sits under the multi-frame animation controller, which supplies frame bytes through a combinational address→data lookup and restarts the block each frame.

## Interface
- `LAYER_ON_CYCLES`, default 5000: cycles each layer stays lit per scan (≥1).
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle pulse; begins or restarts a scan at layer 0.
- `stop` input 1: level/pulse; aborts the scan, blanks outputs, goes idle.
- `done` output 1: one-cycle pulse after a full 8-layer scan completes.
- `addr` output 6: frame byte address `{layer[2:0], row[2:0]}`.
- `data_to_latch` input 8: frame byte for `addr`, valid combinationally in the same cycle.
- `Layers` output 8: one-hot layer enable; 0 = all layers off.
- `Latches` output 8: one-hot latch clock strobe for column latch `row`.
- `Data` output 8: byte presented on the shared latch data bus.

## Operation
- The FSM states are IDLE, SETUP, STROBE, HOLD and SHOW. All outputs are registered and depend only on state and counters.
- IDLE:
  - All outputs are 0.
  - `start` with `stop` low → SETUP with layer=0, row=0.
- SETUP:
  - `addr` = `{layer,row}`.
  - `Latches` = 0 and `Layers` = 0.
  - `Data` captures `data_to_latch` at the end of the cycle.
- STROBE:
  - `Latches` = 1<<row for exactly one cycle.
  - `Data` is stable.
- HOLD:
  - `Latches` = 0 and `Data` is held.
  - If row≠7: row+1 → SETUP.
  - If row=7: → SHOW.
- SHOW:
  - `Layers` = 1<<layer for `LAYER_ON_CYCLES` cycles.
  - `Latches` = 0.
  - Then: if layer≠7, layer+1, row=0 → SETUP.
  - If layer=7, layer wraps to 0, row=0 → SETUP, and `done` pulses in that first SETUP cycle.
- `Layers` is 0 during every load phase (anti-ghosting blanking).
- `stop` has priority in every state: next cycle → IDLE, and all outputs and counters clear to 0.
- `start` and `stop` asserted together → `stop` wins.
- `start` in any non-IDLE state (with `stop` low) → restart: next cycle SETUP, layer=0, row=0, `Layers` cleared.
- The scan never terminates on its own; it wraps after layer 7.
- Counters are 3-bit (layer, row) and wrap naturally. The on-time counter is sized as $clog2(`LAYER_ON_CYCLES`+1).

## Timing
- Reset (`rst_n`=0 at a clock edge) → IDLE; `Layers`, `Latches`, `Data`, `addr` = 0 and `done` = 0. Reset mid-scan is identical.
- Cycle numbering from the `start` cycle (cycle 0):
  - Cycle 1: SETUP, `addr`=0.
  - Cycle 2: STROBE, `Latches`=8'h01, `Data`=byte[0].
  - Cycle 3: HOLD.
  - Cycle 4: SETUP, `addr`=1.
- Load phase per layer: 24 cycles. Layer 0 SHOW occupies cycles 25 … 24+L.
- Scan period: 8·(24+L) cycles. `done` first pulses at cycle 1+8·(24+L).
- `Data` changes only on the SETUP→STROBE edge, so it is stable for the full `Latches` pulse and one cycle after.

## Structure
- A shared package `led_cube_pkg` holds:
  - the state enum `frame_state_t` (IDLE, SETUP, STROBE, HOLD, SHOW);
  - the constants `CUBE_DIM`=8 and `LOAD_CYCLES_PER_BYTE`=3.
- Single module, no sub-modules. The on-time counter is inline.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `start`=1 → all outputs 0, `done`=0, state IDLE.
- Single layer load (L=4): pulse `start` → `addr` steps 0..7 every 3 cycles; `Latches` = 01,02,…,80 on cycles 2,5,…,23; `Data` equals `mem[addr]`; `Layers`=0 until cycle 25, then 8'h01 for 4 cycles.
- Full scan (L=4): `addr` reaches 63. `Layers` visits 01→80 once per scan. `done` pulses exactly once at cycle 225, then `addr` restarts at 0 with no gap.
- Stop mid-SHOW of layer 3 → next cycle all outputs 0, IDLE; no further `done`.
- Restart during layer 5 load with `start` → next cycle `addr`=0, `Layers`=0, scan from layer 0. `start`+`stop` in the same cycle → IDLE.
- Continuous run (L=4, memory pattern byte[i]=i): 3 consecutive scans produce identical `Data`/`Latches` sequences, with `done` spacing of 224 cycles.

Source files
------------

// File: rtl/led_cube_pkg.sv
// Shared types and constants for the LED cube frame driver.
package led_cube_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        SHOW
    } frame_state_t;

    localparam int unsigned CUBE_DIM             = 8;
    localparam int unsigned LOAD_CYCLES_PER_BYTE = 3;

endpackage

// File: rtl/led_cube_single_frame.sv
// Scans one 64-byte frame onto an 8x8x8 cube: load 8 column latches per layer,
// then light that layer for LAYER_ON_CYCLES; repeats until stopped.
module led_cube_single_frame
    import led_cube_pkg::*;
#(
    parameter int unsigned LAYER_ON_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic       done,
    output logic [5:0] addr,
    input  logic [7:0] data_to_latch,
    output logic [7:0] Layers,
    output logic [7:0] Latches,
    output logic [7:0] Data
);

    localparam int unsigned ON_W     = $clog2(LAYER_ON_CYCLES + 1);
    localparam logic [2:0]  LAST_IDX = 3'(CUBE_DIM - 1);

    frame_state_t    state_q, state_d;
    logic [2:0]      layer_q, layer_d;
    logic [2:0]      row_q, row_d;
    logic [ON_W-1:0] on_cnt_q, on_cnt_d;
    logic            done_q, done_d;
    logic [5:0]      addr_q, addr_d;
    logic [7:0]      layers_q, layers_d;
    logic [7:0]      latches_q, latches_d;
    logic [7:0]      data_q, data_d;

    // Next state and registered-output values; stop beats start beats the scan.
    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        row_d     = row_q;
        on_cnt_d  = on_cnt_q;
        done_d    = 1'b0;
        addr_d    = addr_q;
        layers_d  = layers_q;
        latches_d = 8'h00;
        data_d    = data_q;

        if (stop) begin
            state_d  = IDLE;
            layer_d  = 3'd0;
            row_d    = 3'd0;
            on_cnt_d = '0;
            addr_d   = 6'd0;
            layers_d = 8'h00;
            data_d   = 8'h00;
        end else if (start) begin
            state_d  = SETUP;
            layer_d  = 3'd0;
            row_d    = 3'd0;
            on_cnt_d = '0;
            addr_d   = 6'd0;
            layers_d = 8'h00;
        end else begin
            unique case (state_q)
                IDLE: ;
                SETUP: begin
                    data_d    = data_to_latch;
                    latches_d = 8'(8'd1 << row_q);
                    state_d   = STROBE;
                end
                STROBE: state_d = HOLD;
                HOLD: begin
                    if (row_q != LAST_IDX) begin
                        row_d   = row_q + 3'd1;
                        addr_d  = {layer_q, row_q + 3'd1};
                        state_d = SETUP;
                    end else begin
                        layers_d = 8'(8'd1 << layer_q);
                        on_cnt_d = ON_W'(LAYER_ON_CYCLES - 1);
                        state_d  = SHOW;
                    end
                end
                SHOW: begin
                    if (on_cnt_q == '0) begin
                        // Blank before the next load; layer wraps naturally after 7.
                        layers_d = 8'h00;
                        layer_d  = layer_q + 3'd1;
                        row_d    = 3'd0;
                        addr_d   = {layer_q + 3'd1, 3'd0};
                        done_d   = (layer_q == LAST_IDX);
                        state_d  = SETUP;
                    end else begin
                        on_cnt_d = on_cnt_q - ON_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            layer_q   <= 3'd0;
            row_q     <= 3'd0;
            on_cnt_q  <= '0;
            done_q    <= 1'b0;
            addr_q    <= 6'd0;
            layers_q  <= 8'h00;
            latches_q <= 8'h00;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            row_q     <= row_d;
            on_cnt_q  <= on_cnt_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            layers_q  <= layers_d;
            latches_q <= latches_d;
            data_q    <= data_d;
        end
    end

    assign done    = done_q;
    assign addr    = addr_q;
    assign Layers  = layers_q;
    assign Latches = latches_q;
    assign Data    = data_q;

endmodule

// File: tb/tb_led_cube_single_frame.sv
// Bench for led_cube_single_frame: cycle-indexed scan model plus directed checks.
module tb_led_cube_single_frame;

    localparam int unsigned L    = 4;
    localparam int          P    = 24 + L;
    localparam int          SCAN = 8 * P;

    logic       clk = 1'b0;
    logic       rst_n, start, stop;
    logic       done;
    logic [5:0] addr;
    logic [7:0] data_to_latch, Layers, Latches, Data;
    logic [7:0] mem [64];

    always #5 clk = ~clk;

    assign data_to_latch = mem[addr];

    led_cube_single_frame #(.LAYER_ON_CYCLES(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .done(done),
        .addr(addr), .data_to_latch(data_to_latch),
        .Layers(Layers), .Latches(Latches), .Data(Data)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: while active, k counts cycles since the start edge (k=1 is the first SETUP).
    bit         active = 1'b0;
    bit         mvalid = 1'b0;
    int         k      = 0;
    logic [7:0] data_hold     = 8'h00;
    logic [7:0] last_exp_data = 8'h00;

    always @(posedge clk) begin
        if (!rst_n) mvalid <= 1'b1;
        if (!rst_n || stop) begin
            active <= 1'b0;
        end else if (start) begin
            active    <= 1'b1;
            k         <= 1;
            data_hold <= last_exp_data;
        end else if (active) begin
            k <= k + 1;
        end
    end

    int         s, lay, r, row, ph;
    logic [5:0] e_addr;
    logic [7:0] e_lay, e_lat, e_data;
    logic       e_done;

    always @(negedge clk) begin
        if (mvalid) begin
            e_addr = 6'd0; e_lay = 8'h00; e_lat = 8'h00; e_data = 8'h00; e_done = 1'b0;
            if (active) begin
                s   = (k - 1) % SCAN;
                lay = s / P;
                r   = s % P;
                e_done = (s == 0) && (k > 1);
                if (r < 24) begin
                    row    = r / 3;
                    ph     = r % 3;
                    e_addr = 6'(lay * 8 + row);
                    if (ph == 1) e_lat = 8'(1 << row);
                    if (ph != 0)      e_data = mem[lay * 8 + row];
                    else if (row > 0) e_data = mem[lay * 8 + row - 1];
                    else if (k > 1)   e_data = mem[((lay + 7) % 8) * 8 + 7];
                    else              e_data = data_hold;
                end else begin
                    e_addr = 6'(lay * 8 + 7);
                    e_lay  = 8'(1 << lay);
                    e_data = mem[lay * 8 + 7];
                end
            end
            chk("m_addr",    32'(addr),    32'(e_addr));
            chk("m_layers",  32'(Layers),  32'(e_lay));
            chk("m_latches", 32'(Latches), 32'(e_lat));
            chk("m_data",    32'(Data),    32'(e_data));
            chk("m_done",    32'(done),    32'(e_done));
            last_exp_data = e_data;
        end
    end

    int kt = 0;

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kt = 1;
    endtask

    task automatic step_to(input int t);
        while (kt < t) begin
            @(negedge clk);
            kt++;
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_layers"},  32'(Layers),  32'h0);
        chk({name, "_latches"}, 32'(Latches), 32'h0);
        chk({name, "_data"},    32'(Data),    32'h0);
        chk({name, "_addr"},    32'(addr),    32'h0);
        chk({name, "_done"},    32'(done),    32'h0);
    endtask

    logic [15:0] seq [3][SCAN];
    int          done_at [4];
    int          done_cnt;
    int          mis1, mis2;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 5);
        rst_n = 1'b0; start = 1'b1; stop = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);

        // Layer load and first full scan
        kick();
        chk("c1_addr", 32'(addr), 32'h0);
        step_to(2);
        chk("c2_latches", 32'(Latches), 32'h01);
        chk("c2_data", 32'(Data), 32'(mem[0]));
        step_to(4);
        chk("c4_addr", 32'(addr), 32'h1);
        step_to(23);
        chk("c23_latches", 32'(Latches), 32'h80);
        chk("c23_data", 32'(Data), 32'(mem[7]));
        step_to(24);
        chk("c24_layers", 32'(Layers), 32'h00);
        step_to(25);
        chk("c25_layers", 32'(Layers), 32'h01);
        step_to(28);
        chk("c28_layers", 32'(Layers), 32'h01);
        step_to(29);
        chk("c29_layers", 32'(Layers), 32'h00);
        chk("c29_addr", 32'(addr), 32'h08);
        step_to(218);
        chk("c218_addr", 32'(addr), 32'd63);
        step_to(224);
        chk("c224_layers", 32'(Layers), 32'h80);
        chk("c224_done", 32'(done), 32'h0);
        step_to(225);
        chk("c225_done", 32'(done), 32'h1);
        chk("c225_addr", 32'(addr), 32'h0);
        step_to(226);
        chk("c226_done", 32'(done), 32'h0);

        // Stop in the middle of layer 3 SHOW of the second scan
        step_to(334);
        chk("show3_layers", 32'(Layers), 32'h08);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_all_zero("stop");
        repeat (300) @(negedge clk);
        chk_all_zero("idle_after_stop");

        // Restart during the layer 5 load, then start+stop together
        kick();
        step_to(148);
        chk("l5_layers", 32'(Layers), 32'h00);
        chk("l5_addr", 32'(addr), 32'd42);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kt = 1;
        chk("restart_addr", 32'(addr), 32'h0);
        chk("restart_layers", 32'(Layers), 32'h0);
        step_to(2);
        chk("restart_latches", 32'(Latches), 32'h01);
        step_to(30);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk_all_zero("start_stop");
        repeat (5) @(negedge clk);

        // Continuous run over three scans with byte[i] = i
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        done_cnt = 0;
        kick();
        while (kt <= 3 * SCAN + 2) begin
            if (kt <= 3 * SCAN) seq[(kt - 1) / SCAN][(kt - 1) % SCAN] = {Data, Latches};
            if (done === 1'b1) begin
                if (done_cnt < 4) done_at[done_cnt] = kt;
                done_cnt++;
            end
            @(negedge clk);
            kt++;
        end
        chk("done_count", 32'(done_cnt), 32'd3);
        chk("done_first", 32'(done_at[0]), 32'd225);
        chk("done_space1", 32'(done_at[1] - done_at[0]), 32'd224);
        chk("done_space2", 32'(done_at[2] - done_at[1]), 32'd224);
        mis1 = 0; mis2 = 0;
        for (int i = 1; i < SCAN; i++) begin
            if (seq[1][i] !== seq[0][i]) mis1++;
            if (seq[2][i] !== seq[0][i]) mis2++;
        end
        chk("scan1_vs_scan0", 32'(mis1), 32'd0);
        chk("scan2_vs_scan0", 32'(mis2), 32'd0);
        chk("scan_byte9", 32'(seq[1][4 + 28]), 32'({8'd9, 8'h02}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
